// File: rtl/wb_pulse_gen.sv
// Wishbone pulse-train generator: programmable width/period/count, level IRQ on burst completion.
// Single-cycle registered ack (one access per two cycles); `WB_PULSE_EXT_TRIG_EN adds trig_i start.
module wb_pulse_gen #(
   parameter int unsigned clk_freq = 32'd50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        pulse_o,
`ifdef WB_PULSE_EXT_TRIG_EN
   output logic        intr,
   input  logic        trig_i
`else
   output logic        intr
`endif
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      state_q, state_d;
   logic        ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic        done_q, done_d;
   logic        irqen_q, irqen_d;
   logic        pol_q, pol_d;
   logic        en_q, en_d;
   logic [31:0] width_q, width_d;
   logic [31:0] period_q, period_d;
   logic [31:0] count_q, count_d;
   logic [31:0] width_s_q, width_s_d;
   logic [31:0] period_s_q, period_s_d;
   logic [31:0] counter_q, counter_d;
   logic [31:0] remain_q, remain_d;

   logic        acc, wr, pcr_wr, start, busy, trig_fall;
   logic [31:0] period_eff, rdata;

   logic unused_ok;
   assign unused_ok = ^{wb_sel_i, wb_adr_i[31:8], clk_freq};

`ifdef WB_PULSE_EXT_TRIG_EN
   logic trig_s1_q, trig_s2_q, trig_s3_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         trig_s1_q <= 1'b0;
         trig_s2_q <= 1'b0;
         trig_s3_q <= 1'b0;
      end else begin
         trig_s1_q <= trig_i;
         trig_s2_q <= trig_s1_q;
         trig_s3_q <= trig_s2_q;
      end
   end

   assign trig_fall = trig_s3_q & ~trig_s2_q;
`else
   assign trig_fall = 1'b0;
`endif

   assign busy       = (state_q == S_RUN);
   assign wb_ack_o   = wb_stb_i & wb_cyc_i & ack_q;
   assign wb_dat_o   = dat_q;
   assign intr       = done_q & irqen_q;
   assign pulse_o    = (busy && (counter_q <= width_s_q)) ? ~pol_q : pol_q;
   assign period_eff = (period_q == 32'd0) ? 32'd1 : period_q;

   always_comb begin
      state_d    = state_q;
      done_d     = done_q;
      irqen_d    = irqen_q;
      pol_d      = pol_q;
      en_d       = en_q;
      width_d    = width_q;
      period_d   = period_q;
      count_d    = count_q;
      width_s_d  = width_s_q;
      period_s_d = period_s_q;
      counter_d  = counter_q;
      remain_d   = remain_q;
      start      = 1'b0;
      rdata      = 32'd0;

      acc    = wb_stb_i & wb_cyc_i & ~ack_q;
      wr     = acc & wb_we_i;
      pcr_wr = wr && (wb_adr_i[7:0] == 8'h00);
      ack_d  = acc;

      case (wb_adr_i[7:0])
         8'h00:   rdata = {27'd0, busy, en_q, pol_q, irqen_q, done_q};
         8'h04:   rdata = width_q;
         8'h08:   rdata = period_q;
         8'h0C:   rdata = count_q;
         8'h10:   rdata = counter_q;
         8'h14:   rdata = remain_q;
         default: rdata = 32'd0;
      endcase
      dat_d = (acc && !wb_we_i) ? rdata : dat_q;

      if (wr) begin
         case (wb_adr_i[7:0])
            8'h04:   width_d  = wb_dat_i;
            8'h08:   period_d = wb_dat_i;
            8'h0C:   count_d  = wb_dat_i;
            default: ;
         endcase
      end

      // REMAIN==0 while running marks a continuous burst, so later COUNT writes cannot affect it
      if (state_q == S_RUN) begin
         if (counter_q == period_s_q) begin
            if (remain_q == 32'd0 || remain_q > 32'd1) begin
               counter_d  = 32'd1;
               remain_d   = (remain_q == 32'd0) ? 32'd0 : remain_q - 32'd1;
               width_s_d  = width_q;
               period_s_d = period_eff;
            end else begin
               state_d   = S_IDLE;
               en_d      = 1'b0;
               done_d    = 1'b1;
               counter_d = 32'd0;
               remain_d  = 32'd0;
            end
         end else begin
            counter_d = counter_q + 32'd1;
         end
      end

      // PCR write overrides the sequencer, including a burst ending this cycle
      if (pcr_wr) begin
         done_d  = 1'b0;
         irqen_d = wb_dat_i[1];
         pol_d   = wb_dat_i[2];
         en_d    = wb_dat_i[3];
         if (wb_dat_i[3]) begin
            if (state_d == S_IDLE) start = 1'b1;
         end else begin
            state_d   = S_IDLE;
            counter_d = 32'd0;
            remain_d  = 32'd0;
         end
      end else if (trig_fall && state_q == S_IDLE) begin
         start  = 1'b1;
         en_d   = 1'b1;
         done_d = 1'b0;
      end

      if (start) begin
         state_d    = S_RUN;
         counter_d  = 32'd1;
         remain_d   = count_q;
         width_s_d  = width_q;
         period_s_d = period_eff;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ack_q      <= 1'b0;
         dat_q      <= 32'd0;
         done_q     <= 1'b0;
         irqen_q    <= 1'b0;
         pol_q      <= 1'b0;
         en_q       <= 1'b0;
         width_q    <= 32'd0;
         period_q   <= 32'hFFFF_FFFF;
         count_q    <= 32'd1;
         width_s_q  <= 32'd0;
         period_s_q <= 32'hFFFF_FFFF;
         counter_q  <= 32'd0;
         remain_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         done_q     <= done_d;
         irqen_q    <= irqen_d;
         pol_q      <= pol_d;
         en_q       <= en_d;
         width_q    <= width_d;
         period_q   <= period_d;
         count_q    <= count_d;
         width_s_q  <= width_s_d;
         period_s_q <= period_s_d;
         counter_q  <= counter_d;
         remain_q   <= remain_d;
      end
   end

endmodule

// File: doc/wb_pulse_gen.md
# wb_pulse_gen

Wishbone-mapped pulse-train generator for the sensor node: drives a programmable-width, programmable-period pulse on an output pin, such as an ultrasonic/sensor trigger, for a fixed number of periods or continuously. It is the output-side counterpart of the input-capture timer and sits on the same LM32 Wishbone peripheral bus. It raises a level interrupt when a finite burst completes.

## Interface
- `clk_freq`, 50000000: system clock frequency in Hz; informational only, no logic depends on it.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `wb_stb_i`  in  1  Wishbone strobe.
- `wb_cyc_i`  in  1  Wishbone cycle.
- `wb_ack_o`  out  1  Wishbone acknowledge.
- `wb_we_i`  in  1  write enable.
- `wb_adr_i`  in  32  byte address; only [7:0] decoded.
- `wb_sel_i`  in  4  byte selects; ignored, all accesses are full-word.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data, registered.
- `pulse_o`  out  1  generated pulse; idle level = POL.
- `intr`  out  1  DONE & IRQEN, level.
- `trig_i`  in  1  external start; present only with `WB_PULSE_EXT_TRIG_EN`.

## Operation
- Register map:
  - 0x00 PCR: bit0 DONE (ro), bit1 IRQEN, bit2 POL, bit3 EN, bit4 BUSY (ro); bits [31:5] read 0.
  - 0x04 WIDTH: active cycles per period.
  - 0x08 PERIOD: cycles per period; 0 is treated as 1.
  - 0x0C COUNT: periods per burst; 0 means continuous.
  - 0x10 COUNTER (ro): position in the current period, 1..PERIOD; reads 0 when idle.
  - 0x14 REMAIN (ro): periods left, including the current one.
  - Unmapped reads return 0. Writes to read-only or unmapped addresses are acked and have no effect.
- Reset values: `pulse_o`=0, `intr`=0, `wb_ack_o`=0, `wb_dat_o`=0, PCR=0, WIDTH=0, PERIOD=32'hFFFFFFFF, COUNT=1, COUNTER=0, REMAIN=0.
- States:
  - IDLE (BUSY=0): `pulse_o`=POL.
  - RUN (BUSY=1): `pulse_o`=~POL while COUNTER ≤ WIDTH_s, otherwise POL.
- Start condition: a PCR write with EN=1 while IDLE, or an external trigger.
  - The write clears DONE.
  - Latches shadow registers WIDTH_s/PERIOD_s from WIDTH/PERIOD.
  - Sets COUNTER=1 and REMAIN=COUNT, then enters RUN.
- COUNTER increments each cycle in RUN.
- At COUNTER==PERIOD_s (end of a period):
  - If COUNT==0, or REMAIN>1: COUNTER←1, REMAIN decrements (unless COUNT==0), and the shadows reload from WIDTH/PERIOD.
  - Otherwise: go to IDLE, EN←0, DONE←1, COUNTER←0, REMAIN←0.
- Writes to WIDTH, PERIOD or COUNT during RUN do not disturb the current period. WIDTH/PERIOD take effect at the next period boundary. COUNT is used only at the next start.
- WIDTH ≥ PERIOD_s: output is active for the whole period. WIDTH=0: output stays at the idle level while periods are still timed.
- PCR write with EN=0 during RUN (abort): IDLE next cycle, `pulse_o`←POL, DONE unchanged.
- PCR write with EN=1 during RUN: updates IRQEN/POL, clears DONE, no restart.
- Any PCR write clears DONE. POL changes take effect on the next cycle.
- Simultaneous events:
  - A PCR write in the same cycle as a burst end: the write wins. DONE ends at 0; if EN=1 was written, a fresh burst starts.
  - An external trigger in the same cycle as a software start: one start only.
- Arithmetic: all counters are 32-bit unsigned. COUNTER never exceeds PERIOD_s, so no wrap occurs.

## Timing
- Wishbone handshake:
  - `ack` is registered; `wb_ack_o` = `wb_stb_i` & `wb_cyc_i` & `ack`.
  - A strobe in cycle T gives `wb_ack_o` in T+1; `ack` deasserts in T+2, so there is one access per two cycles.
  - Read data is valid in T+1. A write commits at the edge ending T.
- Start by write in cycle T:
  - `pulse_o` is active in cycles T+1..T+WIDTH.
  - It is idle in T+WIDTH+1..T+PERIOD.
  - The next period begins at T+PERIOD+1.
- Burst end: DONE, `intr` (if IRQEN) and EN=0 are visible in the cycle after the last cycle of the final period.
- Abort: `pulse_o` reaches the idle level at T+1.
- Reset: a reset asserted in any state forces all reset values at the next edge.

## Configuration
- `WB_PULSE_EXT_TRIG_EN` defined: adds the `trig_i` input.
  - `trig_i` passes through a 2-flop synchronizer, then falling-edge detection.
  - A falling edge while IDLE starts a burst exactly as an EN=1 write and sets EN=1. It is ignored while in RUN.
  - `pulse_o` becomes active 3 clock edges after `trig_i` low is first sampled.
- `WB_PULSE_EXT_TRIG_EN` undefined: no `trig_i` port and no synchronizer logic; only software start is possible.

## Test plan
- Reset, then read 0x00–0x14 → 0, 0, 32'hFFFFFFFF, 1, 0, 0; `pulse_o`=0, `intr`=0.
- WIDTH=3, PERIOD=10, COUNT=2, IRQEN, write PCR EN=1 in cycle T → `pulse_o` high at T+1..T+3 and T+11..T+13; DONE=1, EN=0 and `intr`=1 at T+21.
- COUNT=0, WIDTH=2, PERIOD=5; write WIDTH=4 mid-period → the current period stays 2 high, the next period is 4 high; write EN=0 → `pulse_o`=0 the next cycle and DONE stays 0.
- POL=1, WIDTH=0, PERIOD=4, COUNT=1 → `pulse_o` stays 1 throughout; DONE at T+5. Separately, WIDTH=9, PERIOD=4 → `pulse_o`=0 for all 4 cycles.
- PERIOD=0, WIDTH=1, COUNT=3 → three 1-cycle periods with `pulse_o` high continuously for 3 cycles; DONE set. A PCR write in the burst-end cycle leaves DONE=0.
- With `WB_PULSE_EXT_TRIG_EN`: WIDTH=2, PERIOD=6, COUNT=1; drive `trig_i` 1→0 → `pulse_o` high for 2 cycles starting 3 edges later. A second falling edge during RUN is ignored (the burst is still exactly 6 cycles).
